// File: rtl/io_uart_tx.sv
// Serial output stage for the Neander-X OUT port: a 4-entry byte FIFO
// feeding an 8N1 transmitter, with a registered status byte for the CPU.
module io_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_out,
  input  logic       io_write,
  output logic       tx,
  output logic [7:0] io_status
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [2:0] count_nx;
  logic       overflow;
  logic       ovf_nx;

  state_t     state;
  state_t     state_nx;
  logic [7:0] baud_cnt;
  logic [7:0] baud_nx;
  logic [2:0] bit_cnt;
  logic [2:0] bit_nx;
  logic [7:0] shift_reg;
  logic [7:0] shift_nx;
  logic       tx_nx;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic last_tick;

  assign full      = (count == 3'd4);
  assign empty     = (count == 3'd0);
  assign push      = io_write && !full;
  assign last_tick = (baud_cnt == BAUD_LAST);

  // A write into a full FIFO is dropped even if a pop frees a slot
  // on the same edge; the sticky flag records it.
  assign ovf_nx   = overflow | (io_write & full);
  assign count_nx = count + {2'b00, push} - {2'b00, pop};

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift_reg;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          bit_nx   = 3'd0;
          baud_nx  = 8'd0;
          state_nx = START;
        end
      end
      START: begin
        if (last_tick) begin
          baud_nx  = 8'd0;
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + 8'd1;
        end
      end
      DATA: begin
        if (last_tick) begin
          baud_nx  = 8'd0;
          shift_nx = {1'b0, shift_reg[7:1]};
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end else begin
          baud_nx = baud_cnt + 8'd1;
        end
      end
      STOP: begin
        if (last_tick) begin
          baud_nx = 8'd0;
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            bit_nx   = 3'd0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is derived from the next state so tx is a clean flop.
  always_comb begin
    tx_nx = 1'b1;
    unique case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      baud_cnt  <= 8'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      tx        <= 1'b1;
      io_status <= 8'h02;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count     <= count_nx;
      overflow  <= ovf_nx;
      baud_cnt  <= baud_nx;
      bit_cnt   <= bit_nx;
      shift_reg <= shift_nx;
      tx        <= tx_nx;
      io_status <= {4'b0000, ovf_nx, (state_nx != IDLE),
                    (count_nx == 3'd0), (count_nx == 3'd4)};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_out;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench for io_uart_tx: a cycle-level occupancy model predicts
// status and accepted bytes; a line monitor decodes frames off tx.
module tb_io_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] io_out;
  logic       io_write;
  logic       tx;
  logic [7:0] io_status;

  always #5 clk = ~clk;

  io_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_out   (io_out),
    .io_write (io_write),
    .tx       (tx),
    .io_status(io_status)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] expq [$];
  int m_cnt  = 0;
  int m_left = 0;
  bit m_ovf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {4'b0000, m_ovf, (m_left > 0), (m_cnt == 0), (m_cnt == 4)};
  endfunction

  // One clock: drive at negedge, advance the model, check after the edge.
  task automatic cycle(input bit wr, input logic [7:0] d);
    bit pop;
    @(negedge clk);
    io_write = wr;
    io_out   = d;
    pop = (m_cnt > 0) && (m_left <= 1);
    if (wr) begin
      if (m_cnt == 4) m_ovf = 1'b1;
      else begin
        m_cnt++;
        expq.push_back(d);
      end
    end
    if (pop) begin
      m_cnt--;
      m_left = FRAME;
    end else if (m_left > 0) begin
      m_left--;
    end
    @(posedge clk);
    #1;
    check("status", io_status, exp_status());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic drain();
    int k = 0;
    while ((m_cnt > 0 || m_left > 0) && k < 3000) begin
      cycle(1'b0, 8'h00);
      k++;
    end
    idle(2);
    check("frames_out", expq.size(), 0);
  endtask

  task automatic reset_model();
    m_cnt  = 0;
    m_left = 0;
    m_ovf  = 1'b0;
    expq.delete();
  endtask

  // Line monitor: samples tx every cycle across a frame.
  logic       s [FRAME];
  initial begin
    bit         ok;
    bit         aborted;
    logic [7:0] data;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      s[0]    = 1'b0;
      aborted = 1'b0;
      for (int i = 1; i < FRAME; i++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        s[i] = tx;
      end
      if (aborted) continue;
      ok = 1'b1;
      for (int b = 0; b < 10; b++)
        for (int k = 1; k < CPB; k++)
          if (s[b*CPB+k] !== s[b*CPB]) ok = 1'b0;
      if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) ok = 1'b0;
      for (int j = 0; j < 8; j++) data[j] = s[(j+1)*CPB];
      check("frame_shape", ok, 1);
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got %0h want none", data);
      end else begin
        check("byte", data, expq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    io_write = 1'b0;
    io_out   = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_status", io_status, 8'h02);
    reset = 1'b0;

    // single byte
    cycle(1'b1, 8'hA5);
    drain();
    check("single_final_status", io_status, 8'h02);

    // back-to-back
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    drain();

    // simultaneous push and pop with two queued
    cycle(1'b1, 8'h21);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h23);
    while (m_left != 1) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h24);
    check("pushpop_status", io_status, 8'h04);
    drain();

    // full and overflow
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i));
    drain();
    check("ovf_sticky", io_status, 8'h0A);

    // reset during DATA bit 3 of 8'hC3 (bit 3 is 0)
    cycle(1'b1, 8'hC3);
    idle(18);
    check("pre_reset_tx", tx, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_tx", tx, 1);
    check("async_status", io_status, 8'h02);
    reset_model();
    @(negedge clk);
    io_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 8'h5A);
    drain();

    // pointer wrap
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 8'($urandom));
      drain();
    end

    // random bursts
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 6);
      repeat (n) cycle(1'b1, 8'($urandom));
      idle($urandom_range(0, 60));
    end
    repeat (300) cycle($urandom_range(0, 7) == 0, 8'($urandom));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
